// File: rtl/br_lite_ni_pkg.sv
// Shared BrLite types: service code and the flit carried on every mesh link.
`timescale 1ns/1ps
package BrLitePkg;

  typedef logic [1:0] br_svc_t;

  typedef struct packed {
    logic [31:0] payload;
    logic [23:0] seq_source;  // {source x, source y, sequence}
    logic [15:0] target;
    br_svc_t     service;
  } br_data_t;

  localparam int unsigned BR_SEQ_W = 8;

endpackage

// File: rtl/br_lite_ni_fifo.sv
// RX flit buffer: registered head, no fall-through, full checked before pop.
`timescale 1ns/1ps
module br_lite_ni_fifo
  import BrLitePkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter type         data_t = br_data_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  data_t data_i,
  input  logic  pop_i,
  output data_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  data_t            mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count alone defines which
  // entries are meaningful, and data_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/br_lite_ni.sv
// BrLite PE network interface: TX req/ack source and RX sink with flit FIFO.
// Define BR_NI_ECHO_FILTER_EN to drop received flits that carry our own ADDRESS.
`timescale 1ns/1ps
module br_lite_ni
  import BrLitePkg::*;
#(
  parameter logic [15:0] ADDRESS  = 16'h0000,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [31:0] tx_payload_i,
  input  logic [15:0] tx_target_i,
  input  br_svc_t     tx_service_i,
  output br_data_t    noc_flit_o,
  output logic        noc_req_o,
  input  logic        noc_ack_i,
  input  logic        noc_busy_i,
  input  br_data_t    noc_flit_i,
  input  logic        noc_req_i,
  output logic        noc_ack_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output br_data_t    rx_flit_o,
  output logic [7:0]  tx_seq_o
);

  typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} br_ni_tx_state_t;
  typedef enum logic       {R_IDLE, R_ACK}        br_ni_rx_state_t;

  br_ni_tx_state_t     tx_state_q;
  br_ni_rx_state_t     rx_state_q;
  br_data_t            tx_flit_q;
  logic                tx_req_q, rx_ack_q;
  logic [BR_SEQ_W-1:0] seq_q;

  assign tx_ready_o = (tx_state_q == T_IDLE) && !noc_busy_i;
  assign noc_flit_o = tx_flit_q;
  assign noc_req_o  = tx_req_q;
  assign tx_seq_o   = seq_q;

  // Flit is held in tx_flit_q from acceptance until the next acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= T_IDLE;
      tx_req_q   <= 1'b0;
      tx_flit_q  <= '0;
      seq_q      <= '0;
    end else begin
      case (tx_state_q)
        T_IDLE: if (tx_valid_i && tx_ready_o) begin
          tx_flit_q  <= '{payload:    tx_payload_i,
                          seq_source: {ADDRESS, seq_q},
                          target:     tx_target_i,
                          service:    tx_service_i};
          tx_req_q   <= 1'b1;
          tx_state_q <= T_REQ;
        end
        T_REQ: if (noc_ack_i) begin
          tx_req_q   <= 1'b0;
          seq_q      <= seq_q + 8'd1;
          tx_state_q <= T_REL;
        end
        T_REL: if (!noc_ack_i) tx_state_q <= T_IDLE;
        default: tx_state_q <= T_IDLE;
      endcase
    end
  end

  logic fifo_full, fifo_empty, rx_accept, rx_push, is_echo;

`ifdef BR_NI_ECHO_FILTER_EN
  assign is_echo = (noc_flit_i.seq_source[23:8] == ADDRESS);
`else
  assign is_echo = 1'b0;
`endif

  // Echoes are still acknowledged, but only when a slot is free.
  assign rx_accept = (rx_state_q == R_IDLE) && noc_req_i && !fifo_full;
  assign rx_push   = rx_accept && !is_echo;
  assign noc_ack_o = rx_ack_q;
  assign rx_valid_o = !fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q <= R_IDLE;
      rx_ack_q   <= 1'b0;
    end else begin
      case (rx_state_q)
        R_IDLE: if (rx_accept) begin
          rx_ack_q   <= 1'b1;
          rx_state_q <= R_ACK;
        end
        R_ACK: if (!noc_req_i) begin
          rx_ack_q   <= 1'b0;
          rx_state_q <= R_IDLE;
        end
        default: rx_state_q <= R_IDLE;
      endcase
    end
  end

  br_lite_ni_fifo #(
    .DEPTH  (RX_DEPTH),
    .data_t (br_data_t)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rx_push),
    .data_i  (noc_flit_i),
    .pop_i   (rx_valid_o && rx_ready_i),
    .data_o  (rx_flit_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_br_lite_ni.sv
// Scoreboard bench for br_lite_ni: router/PE models push expectations, monitors pop and compare.
`timescale 1ns/1ps
module tb_br_lite_ni;
  import BrLitePkg::*;

  localparam logic [15:0] ADDR  = 16'h0102;
  localparam int          DEPTH = 4;

  logic        clk, rst_ni;
  logic        tx_valid_i, tx_ready_o;
  logic [31:0] tx_payload_i;
  logic [15:0] tx_target_i;
  br_svc_t     tx_service_i;
  br_data_t    noc_flit_o, noc_flit_i, rx_flit_o;
  logic        noc_req_o, noc_ack_i, noc_busy_i, noc_req_i, noc_ack_o;
  logic        rx_valid_o, rx_ready_i;
  logic [7:0]  tx_seq_o;

  br_lite_ni #(.ADDRESS(ADDR), .RX_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_payload_i(tx_payload_i),
    .tx_target_i(tx_target_i), .tx_service_i(tx_service_i),
    .noc_flit_o(noc_flit_o), .noc_req_o(noc_req_o), .noc_ack_i(noc_ack_i),
    .noc_busy_i(noc_busy_i), .noc_flit_i(noc_flit_i), .noc_req_i(noc_req_i),
    .noc_ack_o(noc_ack_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_flit_o(rx_flit_o), .tx_seq_o(tx_seq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  br_data_t   tx_q[$];
  br_data_t   rx_q[$];
  logic [7:0] exp_seq = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_flit(input string name, input br_data_t act, input br_data_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic br_data_t mk(input logic [31:0] pl, input logic [23:0] ss,
                                  input logic [15:0] tg, input br_svc_t sv);
    br_data_t f;
    f.payload    = pl;
    f.seq_source = ss;
    f.target     = tg;
    f.service    = sv;
    return f;
  endfunction

  // Router side of the TX link: ack 2 cycles after req, drop ack 1 cycle after req falls.
  initial begin : tx_router
    br_data_t   e;
    logic [7:0] nxt;
    noc_ack_i = 1'b0;
    e = '0;
    @(posedge rst_ni);
    forever begin
      @(negedge clk);
      if (noc_req_o) begin
        if (tx_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL tx_unexpected: got flit %h expected none", noc_flit_o);
        end else begin
          e = tx_q.pop_front();
          check_flit("tx_flit", noc_flit_o, e);
        end
        @(negedge clk);
        check("tx_req_hold", 32'(noc_req_o), 32'd1);
        check_flit("tx_flit_stable", noc_flit_o, e);
        noc_ack_i = 1'b1;
        @(negedge clk);
        nxt = e.seq_source[7:0] + 8'd1;
        check("tx_req_drop", 32'(noc_req_o), 32'd0);
        check("tx_seq_inc", 32'(tx_seq_o), 32'(nxt));
        check("tx_busy_rel", 32'(tx_ready_o), 32'd0);
        noc_ack_i = 1'b0;
        @(negedge clk);
        check("tx_ready_ret", 32'(tx_ready_o), 32'd1);
      end
    end
  end

  // PE side of the RX FIFO: every pop is compared with the oldest expectation.
  initial begin : pe_rx
    @(posedge rst_ni);
    forever begin
      @(negedge clk);
      #2;
      if (rx_valid_o && rx_ready_i) begin
        if (rx_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rx_unexpected: got flit %h expected none", rx_flit_o);
        end else begin
          check_flit("rx_flit", rx_flit_o, rx_q.pop_front());
        end
      end
    end
  end

  // Called at negedge+1 once tx_ready_o is high with tx_valid_i asserted.
  task automatic tx_commit();
    check("tx_accept", 32'(tx_ready_o), 32'd1);
    check("tx_seq_now", 32'(tx_seq_o), 32'(exp_seq));
    tx_q.push_back(mk(tx_payload_i, {ADDR, exp_seq}, tx_target_i, tx_service_i));
    exp_seq = exp_seq + 8'd1;
    @(negedge clk);
    tx_valid_i = 1'b0;
    check("tx_req_lat", 32'(noc_req_o), 32'd1);
  endtask

  task automatic tx_send(input logic [31:0] pl, input logic [15:0] tg, input br_svc_t sv);
    int w;
    @(negedge clk);
    tx_valid_i = 1'b1; tx_payload_i = pl; tx_target_i = tg; tx_service_i = sv;
    #1;
    w = 0;
    while (!tx_ready_o && w < 60) begin
      @(negedge clk); #1; w++;
    end
    tx_commit();
  endtask

  task automatic rx_inject(input br_data_t f, input bit expect_push);
    int w;
    @(negedge clk);
    noc_flit_i = f;
    noc_req_i  = 1'b1;
    if (expect_push) rx_q.push_back(f);
    w = 0;
    while (noc_ack_o !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    check("rx_ack_seen", 32'(noc_ack_o), 32'd1);
    noc_req_i = 1'b0;
    w = 0;
    while (noc_ack_o !== 1'b0 && w < 40) begin @(negedge clk); w++; end
    check("rx_ack_drop", 32'(noc_ack_o), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w;
    rst_ni = 1'b0;
    tx_valid_i = 1'b0; tx_payload_i = '0; tx_target_i = '0; tx_service_i = '0;
    noc_busy_i = 1'b0; noc_flit_i = '0; noc_req_i = 1'b0; rx_ready_i = 1'b0;
    #12;
    check("rst_req",     32'(noc_req_o),  32'd0);
    check("rst_ack",     32'(noc_ack_o),  32'd0);
    check("rst_rxvalid", 32'(rx_valid_o), 32'd0);
    check("rst_seq",     32'(tx_seq_o),   32'd0);
    check("rst_ready",   32'(tx_ready_o), 32'd1);
    check_flit("rst_txflit", noc_flit_o, '0);
    check_flit("rst_rxflit", rx_flit_o,  '0);
    @(negedge clk);
    rst_ni = 1'b1;
    idle(2);

    // Single TX: first flit must carry seq_source 24'h010200.
    check("first_seq_src", 32'({ADDR, exp_seq}), 32'h0001_0200);
    tx_send(32'hCAFE_0001, 16'h0201, 2'd0);
    idle(6);

    // Router busy holds off acceptance for 5 cycles.
    noc_busy_i = 1'b1;
    tx_valid_i = 1'b1; tx_payload_i = 32'hB05B_0001; tx_target_i = 16'h0303; tx_service_i = 2'd2;
    repeat (5) begin
      #1;
      check("busy_no_ready", 32'(tx_ready_o), 32'd0);
      check("busy_no_req",   32'(noc_req_o),  32'd0);
      @(negedge clk);
    end
    noc_busy_i = 1'b0;
    #1;
    tx_commit();
    idle(6);

    // 256 back-to-back sends wrap the sequence, then one more.
    for (int i = 0; i < 257; i++) tx_send(32'h1000_0000 + 32'(i), 16'h0505, br_svc_t'(i));
    idle(6);
    check("seq_wrapped", 32'(tx_seq_o), 32'd3);

    // RX backpressure with a full FIFO.
    rx_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      rx_inject(mk(32'hD000_0000 + 32'(i), {16'h0300, 8'(i)}, ADDR, br_svc_t'(i)), 1'b1);
    check("rx_valid_full", 32'(rx_valid_o), 32'd1);
    fork
      rx_inject(mk(32'hD000_0004, 24'h030004, ADDR, 2'd3), 1'b1);
      begin
        repeat (6) begin
          @(negedge clk);
          check("rx_backpressure", 32'(noc_ack_o), 32'd0);
        end
        @(negedge clk); rx_ready_i = 1'b1;
        @(negedge clk); rx_ready_i = 1'b0;
        check("rx_no_same_cycle_push", 32'(noc_ack_o), 32'd0);
      end
    join
    rx_ready_i = 1'b1;
    idle(8);
    check("rx_drained", 32'(rx_valid_o), 32'd0);

    // TX and RX at the same time.
    fork
      tx_send(32'h5151_AAAA, 16'h0000, 2'd1);
      begin
        rx_inject(mk(32'hE000_0001, 24'h040001, ADDR, 2'd0), 1'b1);
        rx_inject(mk(32'hE000_0002, 24'h040002, ADDR, 2'd1), 1'b1);
      end
    join
    idle(8);

    // Own broadcast echoed back.
`ifdef BR_NI_ECHO_FILTER_EN
    rx_inject(mk(32'h0000_ECC0, 24'h010207, 16'h0102, 2'd1), 1'b0);
    idle(3);
    check("echo_dropped", 32'(rx_valid_o), 32'd0);
`else
    rx_inject(mk(32'h0000_ECC0, 24'h010207, 16'h0102, 2'd1), 1'b1);
`endif

    w = 0;
    while ((tx_q.size() != 0 || rx_q.size() != 0) && w < 200) begin @(negedge clk); w++; end
    idle(6);
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);
    check("rx_q_drained", 32'(rx_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/br_lite_ni.md
Name: br_lite_ni

Overview:
- PE-side network interface for the BrLite broadcast mesh. It is the far end of a router's LOCAL port.
- TX path: takes PE broadcast requests, stamps each with the source address and a sequence number, and drives them into the router with a four-phase req/ack handshake.
- RX path: answers the router's LOCAL output handshake and buffers delivered flits in a FIFO for the PE.
- One instance per PE, outside the mesh.

Parameters:
- ADDRESS, 16'h0000, own router address as {x[7:0], y[7:0]}; placed in seq_source.
- RX_DEPTH, 4, RX FIFO entries; power of two, minimum 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- tx_valid_i  in  1  PE has a broadcast to send
- tx_ready_o  out  1  NI accepts the request this cycle
- tx_payload_i  in  32  payload
- tx_target_i  in  16  target address
- tx_service_i  in  br_svc_t(2)  service code
- noc_flit_o  out  br_data_t  flit to router LOCAL input
- noc_req_o  out  1  request to router
- noc_ack_i  in  1  router acknowledge
- noc_busy_i  in  1  router local_busy; no new request while high
- noc_flit_i  in  br_data_t  flit from router LOCAL output
- noc_req_i  in  1  router request
- noc_ack_o  out  1  acknowledge to router
- rx_valid_o  out  1  FIFO head valid
- rx_ready_i  in  1  PE pops the head
- rx_flit_o  out  br_data_t  FIFO head
- tx_seq_o  out  8  sequence number the next flit will carry

Behaviour:
- Reset (async, rst_ni=0): all outputs 0 except tx_ready_o, which follows its combinational equation. TX FSM goes to T_IDLE, RX FSM to R_IDLE, FIFO empty, seq=0. Reset during a handshake abandons it; req/ack drop immediately.
- TX FSM, states T_IDLE, T_REQ, T_REL:
  - T_IDLE: tx_ready_o = !noc_busy_i. On tx_valid_i && tx_ready_o, register the flit {payload, seq_source={ADDRESS, seq}, target, service} and go to T_REQ.
  - T_REQ: noc_req_o=1; noc_flit_o is stable from the cycle req rises until release. When noc_ack_i=1: go to T_REL, drop req next cycle, seq <= seq+1 (8-bit wrap, 255->0).
  - T_REL: req=0. Wait for noc_ack_i=0, then go to T_IDLE.
  - tx_ready_o=0 in T_REQ and T_REL.
  - Latency: acceptance at cycle N gives noc_req_o=1 at N+1.
- RX FSM, states R_IDLE, R_ACK:
  - R_IDLE: if noc_req_i=1 and FIFO not full, push noc_flit_i, noc_ack_o=1 from the next cycle, go to R_ACK. If the FIFO is full, hold ack=0 (backpressure) and stay.
  - R_ACK: hold ack=1 until noc_req_i=0, then ack=0 and go to R_IDLE.
  - Exactly one push per req pulse.
- FIFO:
  - Registered output, no fall-through: a push into an empty FIFO gives rx_valid_o=1 the next cycle.
  - Pop on rx_valid_o && rx_ready_i.
  - Push and pop in the same cycle are allowed when the FIFO is neither empty nor full.
  - Full is evaluated before the pop, so a pop while full does not free a slot for that same cycle. The push happens the following cycle.
  - Pointers wrap modulo RX_DEPTH. Count width is $clog2(RX_DEPTH)+1.
- The TX and RX paths are fully independent. Simultaneous activity must not stall either one.

Optional Feature:
- BR_NI_ECHO_FILTER_EN defined: a received flit with seq_source[23:8]==ADDRESS (own broadcast echoed back) is still acknowledged normally but is not pushed into the FIFO. Full-FIFO backpressure still applies.
- BR_NI_ECHO_FILTER_EN undefined: all received flits are pushed.

Decomposition:
- Shared package BrLitePkg: br_svc_t and br_data_t {payload[31:0], seq_source[23:0], target[15:0], service}.
- NI state enums br_ni_tx_state_t and br_ni_rx_state_t live locally in br_lite_ni.
- One sub-module: br_lite_ni_fifo (parameter DEPTH, type br_data_t, push/pop/full/empty).

Test Plan:
- Single TX, ADDRESS=16'h0102, payload 32'hCAFE0001, target 16'h0201. Router acks 2 cycles after req, drops ack 1 cycle after req falls -> noc_req_o rises 1 cycle after accept; flit seq_source=24'h010200; tx_seq_o=1 after ack; tx_ready_o returns after ack low.
- noc_busy_i=1 with tx_valid_i=1 for 5 cycles -> tx_ready_o=0 and no req; accepted on the first cycle busy=0.
- 256 back-to-back sends -> seq values 0..255, then the 257th carries seq 0.
- RX_DEPTH=4 with rx_ready_i=0, 5 router requests -> 4 acked; the 5th req stays un-acked until one pop, then acked; pop order matches push order.
- Simultaneous TX handshake and RX push/pop -> both complete with no lost or duplicated flit.
- With BR_NI_ECHO_FILTER_EN, an incoming flit with seq_source=24'h010207 -> acked, rx_valid_o stays 0. Without the macro -> delivered.
